// File: rtl/noc_router_param.sv
// noc_router_param: 5-port XY mesh router with per-input FIFOs and registered round-robin outputs.
// Define NOC_ROUTER_STATS_EN to add saturating per-output forward counters on fwd_count.
module noc_router_param #(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    localparam int FLIT_W    = X_W + Y_W + DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5*FLIT_W-1:0] in_flit,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_ready,
    output logic [5*FLIT_W-1:0] out_flit,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_ready,
    input  logic                block_all_paths
`ifdef NOC_ROUTER_STATS_EN
    ,
    output logic [5*16-1:0]     fwd_count
`endif
);
    localparam int NP = 5;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [X_W-1:0] MY_XV    = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_YV    = Y_W'(MY_Y);
    localparam logic [2:0]     P_L = 3'd0, P_N = 3'd1, P_E = 3'd2, P_S = 3'd3, P_W = 3'd4;

    logic [FLIT_W-1:0] mem [NP][FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr [NP];
    logic [AW-1:0]     wr_ptr [NP];
    logic [AW:0]       count [NP];
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;

    logic [FLIT_W-1:0] head_p0 [NP];
    logic [NP-1:0]     head_vld_p0;
    logic [2:0]        route_p0 [NP];
    logic [NP-1:0]     grant_p0 [NP];
    logic [NP-1:0]     load_p0;
    logic [FLIT_W-1:0] load_flit_p0 [NP];
    logic [2:0]        rr_ptr [NP];
    logic [2:0]        rr_next [NP];
    int                arb_idx;

    logic [FLIT_W-1:0] flit_p1 [NP];
    logic [NP-1:0]     vld_p1;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            in_ready[p]    = (count[p] != FULL_CNT);
            push[p]        = in_valid[p] & in_ready[p];
            head_p0[p]     = mem[p][rd_ptr[p]];
            head_vld_p0[p] = (count[p] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
                case ({push[p], pop[p]})
                    2'b10:   count[p] <= count[p] + (AW+1)'(1);
                    2'b01:   count[p] <= count[p] - (AW+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    // Storage carries no reset: only the pointers and counts define which entries are live.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= in_flit[p*FLIT_W +: FLIT_W];
        end
    end

    // Stage p0: XY route of each FIFO head, then per-output round-robin grant.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            route_p0[p] = P_L;
            if (head_p0[p][FLIT_W-1 -: X_W] > MY_XV)      route_p0[p] = P_E;
            else if (head_p0[p][FLIT_W-1 -: X_W] < MY_XV) route_p0[p] = P_W;
            else if (head_p0[p][DATA_W +: Y_W] > MY_YV)   route_p0[p] = P_S;
            else if (head_p0[p][DATA_W +: Y_W] < MY_YV)   route_p0[p] = P_N;
        end
    end

    always_comb begin
        arb_idx = 0;
        for (int o = 0; o < NP; o++) begin
            grant_p0[o] = '0;
            rr_next[o]  = rr_ptr[o];
            if (!block_all_paths && (!vld_p1[o] || out_ready[o])) begin
                for (int k = 0; k < NP; k++) begin
                    arb_idx = (int'(rr_ptr[o]) + k) % NP;
                    if (grant_p0[o] == '0 && head_vld_p0[arb_idx] && route_p0[arb_idx] == 3'(o)) begin
                        grant_p0[o][arb_idx] = 1'b1;
                        rr_next[o] = (arb_idx == NP - 1) ? 3'd0 : 3'(arb_idx + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            load_p0[o]      = |grant_p0[o];
            load_flit_p0[o] = '0;
            for (int i = 0; i < NP; i++) begin
                if (grant_p0[o][i]) load_flit_p0[o] = head_p0[i];
            end
            pop = pop | grant_p0[o];
        end
    end

    // Stage p1: one-flit output registers, reloadable in the same cycle they drain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= '0;
            for (int o = 0; o < NP; o++) begin
                flit_p1[o] <= '0;
                rr_ptr[o]  <= '0;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                rr_ptr[o] <= rr_next[o];
                if (load_p0[o]) begin
                    vld_p1[o]  <= 1'b1;
                    flit_p1[o] <= load_flit_p0[o];
                end else if (out_ready[o]) begin
                    vld_p1[o]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_flit = '0;
        for (int o = 0; o < NP; o++) out_flit[o*FLIT_W +: FLIT_W] = flit_p1[o];
    end

    assign out_valid = vld_p1;

`ifdef NOC_ROUTER_STATS_EN
    logic [15:0] fwd_cnt [NP];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < NP; o++) fwd_cnt[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (vld_p1[o] && out_ready[o] && fwd_cnt[o] != 16'hFFFF) fwd_cnt[o] <= fwd_cnt[o] + 16'd1;
            end
        end
    end

    always_comb begin
        fwd_count = '0;
        for (int o = 0; o < NP; o++) fwd_count[o*16 +: 16] = fwd_cnt[o];
    end
`endif

endmodule

// File: tb/tb_noc_router_param.sv
// Testbench for noc_router_param placed at mesh position (1,1): directed scenarios followed by
// a randomized run scored per (source input, output) pair against an XY-routing reference.
`timescale 1ns/1ps
module tb_noc_router_param;
    localparam int XW = 2, YW = 2, DW = 9, FW = XW + YW + DW, NP = 5;
    localparam int MYX = 1, MYY = 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [NP*FW-1:0] in_flit = '0;
    logic [NP-1:0]   in_valid = '0;
    logic [NP-1:0]   in_ready;
    logic [NP*FW-1:0] out_flit;
    logic [NP-1:0]   out_valid;
    logic [NP-1:0]   out_ready = '1;
    logic            block_all_paths = 1'b0;
`ifdef NOC_ROUTER_STATS_EN
    logic [NP*16-1:0] fwd_count;
    int               fwd_model [NP];
`endif

    int n_checks = 0;
    int n_errors = 0;

    noc_router_param #(
        .X_W(XW), .Y_W(YW), .DATA_W(DW), .FIFO_DEPTH(4), .MY_X(MYX), .MY_Y(MYY)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_flit(in_flit),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_flit(out_flit),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .block_all_paths(block_all_paths)
`ifdef NOC_ROUTER_STATS_EN
        ,
        .fwd_count(fwd_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int x, input int y, input int d);
        return {XW'(x), YW'(y), DW'(d)};
    endfunction

    // XY routing reference: 0=Local 1=N 2=E 3=S 4=W
    function automatic int xy_route(input int dx, input int dy);
        if (dx > MYX) return 2;
        if (dx < MYX) return 4;
        if (dy > MYY) return 3;
        if (dy < MYY) return 1;
        return 0;
    endfunction

    function automatic logic [FW-1:0] out_of(input int o);
        return out_flit[o*FW +: FW];
    endfunction

    task automatic set_in(input int p, input logic [FW-1:0] f);
        in_flit[p*FW +: FW] = f;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard for the random phase: one ordered queue per (source, output) pair.
    logic [FW-1:0] exp_q [NP*NP][$];
    int            seq [NP];
    int            n_sent = 0;
    int            n_rcvd = 0;
    bit            mon_en = 1'b0;
    logic [NP-1:0] hold = '0;
    logic [FW-1:0] hold_flit [NP];
    logic [FW-1:0] mon_f;
    int            mon_src;
    int            mon_qn;

    always @(negedge clock) begin
        if (mon_en && reset) begin
            for (int o = 0; o < NP; o++) begin
                mon_f = out_of(o);
                if (hold[o]) begin
                    chk("stall_valid", out_valid[o], 1'b1);
                    chk("stall_flit", mon_f, hold_flit[o]);
                end
                if (out_valid[o] && out_ready[o]) begin
                    mon_src = int'(mon_f[8:6]);
                    mon_qn  = (mon_src < NP) ? exp_q[mon_src*NP + o].size() : 0;
                    chk("sb_expected", mon_qn != 0, 1'b1);
                    if (mon_qn != 0) begin
                        chk("sb_order", mon_f, exp_q[mon_src*NP + o].pop_front());
                        n_rcvd++;
                    end
                end
                hold[o]      = out_valid[o] & ~out_ready[o];
                hold_flit[o] = mon_f;
            end
            for (int p = 0; p < NP; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    mon_f = in_flit[p*FW +: FW];
                    exp_q[p*NP + xy_route(int'(mon_f[12:11]), int'(mon_f[10:9]))].push_back(mon_f);
                    seq[p]++;
                    n_sent++;
                end
            end
        end else begin
            hold = '0;
        end
    end

`ifdef NOC_ROUTER_STATS_EN
    always @(negedge clock) begin
        for (int o = 0; o < NP; o++) begin
            if (!reset) fwd_model[o] = 0;
            else if (out_valid[o] && out_ready[o] && fwd_model[o] < 65535) fwd_model[o]++;
        end
    end
`endif

    int  acc;
    int  rx;
    int  first_low;
    bit  rdy;

    initial begin
        for (int p = 0; p < NP; p++) seq[p] = 0;
        #3 reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 5'b00000);
        chk("rst_in_ready", in_ready, 5'b11111);
        chk("rst_out_flit", out_flit, '0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single flit Local -> East, two-cycle latency
        set_in(0, mk(2, 1, 'h0A5));
        in_valid = 5'b00001;
        tick();
        in_valid = '0;
        chk("lat_early", out_valid, 5'b00000);
        tick();
        chk("lat_valid", out_valid, 5'b00100);
        chk("lat_data", out_of(2), mk(2, 1, 'h0A5));
        tick();
        chk("lat_drain", out_valid, 5'b00000);

        // N, S, W contend for Local
        set_in(1, mk(1, 1, 1));
        set_in(3, mk(1, 1, 3));
        set_in(4, mk(1, 1, 4));
        in_valid = 5'b11010;
        tick();
        in_valid = '0;
        tick();
        chk("rr_first_vld", out_valid, 5'b00001);
        chk("rr_first", out_of(0), mk(1, 1, 1));
        tick();
        chk("rr_second", out_of(0), mk(1, 1, 3));
        tick();
        chk("rr_third", out_of(0), mk(1, 1, 4));
        tick();
        chk("rr_idle", out_valid, 5'b00000);
        // Pointer back at 0: N must beat W
        set_in(1, mk(1, 1, 'h11));
        set_in(4, mk(1, 1, 'h14));
        in_valid = 5'b10010;
        tick();
        in_valid = '0;
        tick();
        chk("rr_ptr_n", out_of(0), mk(1, 1, 'h11));
        tick();
        chk("rr_ptr_w", out_of(0), mk(1, 1, 'h14));

        // Backpressure: East stalled, West streams six flits
        tick();
        out_ready = 5'b11011;
        acc = 0;
        first_low = -1;
        for (int c = 0; c < 10; c++) begin
            set_in(4, mk(3, 1, acc));
            in_valid = 5'b10000;
            rdy = in_ready[4];
            if (!rdy && first_low < 0) first_low = acc;
            tick();
            if (rdy) acc++;
        end
        chk("bp_accepted", acc, 5);
        chk("bp_ready_drop_at", first_low, 5);
        chk("bp_ready_low", in_ready[4], 1'b0);
        chk("bp_hold_vld", out_valid, 5'b00100);
        chk("bp_hold_data", out_of(2), mk(3, 1, 0));
        out_ready = '1;
        rx = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc < 6) begin
                set_in(4, mk(3, 1, acc));
                in_valid = 5'b10000;
            end else begin
                in_valid = '0;
            end
            rdy = in_ready[4];
            if (out_valid[2]) begin
                chk("bp_order", out_of(2), mk(3, 1, rx));
                rx++;
            end
            tick();
            if (rdy && acc < 6) acc++;
        end
        in_valid = '0;
        chk("bp_all_sent", acc, 6);
        chk("bp_all_rcvd", rx, 6);

        // Block all paths
        block_all_paths = 1'b1;
        set_in(0, mk(0, 1, 'h21));
        in_valid = 5'b00001;
        tick();
        set_in(0, mk(0, 1, 'h22));
        tick();
        in_valid = '0;
        for (int c = 0; c < 4; c++) begin
            chk("blk_idle", out_valid, 5'b00000);
            tick();
        end
        block_all_paths = 1'b0;
        tick();
        chk("blk_first_vld", out_valid, 5'b10000);
        chk("blk_first", out_of(4), mk(0, 1, 'h21));
        tick();
        chk("blk_second", out_of(4), mk(0, 1, 'h22));
        tick();
        chk("blk_done", out_valid, 5'b00000);

        // Reset with buffered flits
        out_ready = 5'b11011;
        for (int k = 0; k < 3; k++) begin
            set_in(0, mk(2, 1, 'h40 + k));
            in_valid = 5'b00001;
            tick();
        end
        in_valid = '0;
        tick();
        chk("rst_pre_vld", out_valid, 5'b00100);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_vld", out_valid, 5'b00000);
        chk("rst_mid_ready", in_ready, 5'b11111);
        chk("rst_mid_flit", out_flit, '0);
`ifdef NOC_ROUTER_STATS_EN
        chk("rst_fwd_count", fwd_count, '0);
`endif
        tick();
        reset = 1'b1;
        out_ready = '1;
        set_in(0, mk(2, 1, 'h33));
        in_valid = 5'b00001;
        tick();
        in_valid = '0;
        tick();
        chk("rst_post_vld", out_valid, 5'b00100);
        chk("rst_post_data", out_of(2), mk(2, 1, 'h33));
        tick();
        chk("rst_no_stale0", out_valid, 5'b00000);
        tick();
        chk("rst_no_stale1", out_valid, 5'b00000);

        // Randomized traffic
        mon_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < NP; p++) begin
                in_valid[p] = ($urandom_range(0, 99) < 60);
                set_in(p, mk($urandom_range(0, 3), $urandom_range(0, 3), (p << 6) | (seq[p] & 63)));
            end
            out_ready = 5'($urandom);
            block_all_paths = ($urandom_range(0, 99) < 8);
            tick();
        end
        in_valid = '0;
        out_ready = '1;
        block_all_paths = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (n_rcvd == n_sent) break;
            tick();
        end
        tick();
        chk("rnd_delivered", n_rcvd, n_sent);
        chk("rnd_out_idle", out_valid, 5'b00000);
        mon_en = 1'b0;
`ifdef NOC_ROUTER_STATS_EN
        for (int o = 0; o < NP; o++) chk("fwd_count", fwd_count[o*16 +: 16], fwd_model[o]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
